// File: rtl/xif_aes_issuer.sv
// xif_aes_issuer
// Core-side CV-X-IF initiator that drives one AES32 instruction at a time
// into the AES coprocessor. It runs issue, commit and result in order and
// returns the write-back data or a failure status on the response port.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_*                             local request: instr, rs1, rs2, kill
//   issue_*                           X-IF issue transaction (out: valid/instr/id/rs/rs_valid,
//                                     in: ready/accept)
//   commit_*                          X-IF commit transaction (valid, id, kill)
//   result_*                          X-IF result transaction (in: valid/id/data/rd, out: ready)
//   resp_*                            local response: data, rd, status
//                                     (0 OK, 1 NOT_ACCEPTED, 2 KILLED, 3 TIMEOUT)
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | req_ready high, waiting for a request
// ISSUE       | issue_valid high, holding the issue payload until issue_ready
// COMMIT      | single-cycle commit; the result may arrive in this cycle
// WAIT_RESULT | result_ready high, waiting for a matching result or timeout
// RESP        | resp_valid high, holding the response until resp_ready
module xif_aes_issuer #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_instr,
    input  logic [X_RFR_WIDTH-1:0]   req_rs1,
    input  logic [X_RFR_WIDTH-1:0]   req_rs2,
    input  logic                     req_kill,

    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [31:0]              issue_instr,
    output logic [X_ID_WIDTH-1:0]    issue_id,
    output logic [2*X_RFR_WIDTH-1:0] issue_rs,
    output logic [1:0]               issue_rs_valid,
    input  logic                     issue_accept,

    output logic                     commit_valid,
    output logic [X_ID_WIDTH-1:0]    commit_id,
    output logic                     commit_kill,

    input  logic                     result_valid,
    output logic                     result_ready,
    input  logic [X_ID_WIDTH-1:0]    result_id,
    input  logic [X_RFW_WIDTH-1:0]   result_data,
    input  logic [4:0]               result_rd,

    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [X_RFW_WIDTH-1:0]   resp_data,
    output logic [4:0]               resp_rd,
    output logic [1:0]               resp_status
);

    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NOT_ACC = 2'd1;
    localparam logic [1:0] ST_KILLED  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        COMMIT,
        WAIT_RESULT,
        RESP
    } state_t;

    state_t                state_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic [TW-1:0]         tmo_q;
    logic                  kill_q;
    logic                  accept_q;
    logic                  id_match;

    // The ID only moves on a response handshake, so it is stable for the
    // whole issue/commit/result sequence and can drive both ID outputs.
    assign issue_id  = id_q;
    assign commit_id = id_q;
    assign id_match  = result_valid && (result_id == id_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            id_q           <= '0;
            tmo_q          <= '0;
            kill_q         <= 1'b0;
            accept_q       <= 1'b0;
            req_ready      <= 1'b1;
            issue_valid    <= 1'b0;
            issue_instr    <= '0;
            issue_rs       <= '0;
            issue_rs_valid <= 2'b00;
            commit_valid   <= 1'b0;
            commit_kill    <= 1'b0;
            result_ready   <= 1'b0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            resp_rd        <= '0;
            resp_status    <= ST_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        issue_instr    <= req_instr;
                        issue_rs       <= {req_rs2, req_rs1};
                        issue_rs_valid <= 2'b11;
                        issue_valid    <= 1'b1;
                        kill_q         <= req_kill;
                        req_ready      <= 1'b0;
                        state_q        <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (issue_ready) begin
                        accept_q       <= issue_accept;
                        issue_valid    <= 1'b0;
                        issue_rs_valid <= 2'b00;
                        commit_valid   <= 1'b1;
                        commit_kill    <= kill_q | ~issue_accept;
                        // The coprocessor may answer combinationally with the
                        // commit, so be ready in COMMIT for a live instruction.
                        result_ready   <= issue_accept & ~kill_q;
                        state_q        <= COMMIT;
                    end
                end

                COMMIT: begin
                    commit_valid <= 1'b0;
                    commit_kill  <= 1'b0;
                    if (!accept_q) begin
                        resp_data    <= '0;
                        resp_rd      <= '0;
                        resp_status  <= ST_NOT_ACC;
                        resp_valid   <= 1'b1;
                        result_ready <= 1'b0;
                        state_q      <= RESP;
                    end else if (kill_q) begin
                        resp_data    <= '0;
                        resp_rd      <= '0;
                        resp_status  <= ST_KILLED;
                        resp_valid   <= 1'b1;
                        result_ready <= 1'b0;
                        state_q      <= RESP;
                    end else if (id_match) begin
                        resp_data    <= result_data;
                        resp_rd      <= result_rd;
                        resp_status  <= ST_OK;
                        resp_valid   <= 1'b1;
                        result_ready <= 1'b0;
                        state_q      <= RESP;
                    end else begin
                        tmo_q        <= '0;
                        result_ready <= 1'b1;
                        state_q      <= WAIT_RESULT;
                    end
                end

                WAIT_RESULT: begin
                    // Results with a foreign ID are acknowledged and dropped.
                    if (id_match) begin
                        resp_data    <= result_data;
                        resp_rd      <= result_rd;
                        resp_status  <= ST_OK;
                        resp_valid   <= 1'b1;
                        result_ready <= 1'b0;
                        state_q      <= RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        resp_data    <= '0;
                        resp_rd      <= '0;
                        resp_status  <= ST_TIMEOUT;
                        resp_valid   <= 1'b1;
                        result_ready <= 1'b0;
                        state_q      <= RESP;
                    end else if (tmo_q != {TW{1'b1}}) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        id_q       <= id_q + 1'b1;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xif_aes_issuer.md
# xif_aes_issuer

Core-side initiator for the CV-X-IF eXtension interface that drives AES32 instructions into the AES coprocessor and collects their results. It accepts one instruction plus two source operands from a local request port, then runs the issue, commit and result transactions in order. It returns the write-back data, or a failure status, on a response port. It serves as the integration driver and bring-up harness for the coprocessor, and handles one outstanding instruction at a time.

## Interface
- X_ID_WIDTH, 4: width of the instruction ID.
- X_RFR_WIDTH, 32: source operand width.
- X_RFW_WIDTH, 32: result data width.
- TIMEOUT, 64: maximum number of cycles spent in WAIT_RESULT before the block gives up.
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_instr  in  32  instruction word.
- req_rs1, req_rs2  in  X_RFR_WIDTH  source operands.
- req_kill  in  1  commit this instruction as killed.
- issue_valid  out  1  issue request is valid.
- issue_ready  in  1  coprocessor takes the issue request.
- issue_instr  out  32  instruction word to the coprocessor.
- issue_id  out  X_ID_WIDTH  ID of the issued instruction.
- issue_rs  out  2×X_RFR_WIDTH  operands; index 0 is rs1.
- issue_rs_valid  out  2  operand valid flags.
- issue_accept  in  1  coprocessor accepts the instruction.
- commit_valid  out  1  commit transaction is valid.
- commit_id  out  X_ID_WIDTH  ID being committed.
- commit_kill  out  1  the committed instruction is killed.
- result_valid / result_ready  in / out  1  result handshake.
- result_id  in  X_ID_WIDTH  ID of the returned result.
- result_data  in  X_RFW_WIDTH  result data.
- result_rd  in  5  destination register.
- resp_valid / resp_ready  out / in  1  response handshake.
- resp_data  out  X_RFW_WIDTH  returned data.
- resp_rd  out  5  returned destination register.
- resp_status  out  2  0 = OK, 1 = NOT_ACCEPTED, 2 = KILLED, 3 = TIMEOUT.

## Operation
- **States:** IDLE, ISSUE, COMMIT, WAIT_RESULT, RESP.
- **IDLE:**
  - req_ready = 1.
  - On req_valid, capture instr, rs1, rs2 and kill; go to ISSUE.
- **ISSUE:**
  - issue_valid = 1 and issue_rs_valid = 2'b11.
  - issue_instr, issue_rs and issue_id stay stable until issue_ready.
  - On issue_valid & issue_ready, capture issue_accept; go to COMMIT.
- **COMMIT:** exactly one cycle, with commit_valid = 1 and commit_id = the current ID.
  - commit_kill = captured kill OR NOT captured accept.
  - If not accepted, go to RESP with status NOT_ACCEPTED.
  - Otherwise, if killed, go to RESP with status KILLED.
  - Otherwise go to WAIT_RESULT, unless a matching result was taken this same cycle, in which case go directly to RESP with status OK.
- **WAIT_RESULT:**
  - result_ready = 1.
  - On result_valid & result_id == the current ID, capture data and rd; go to RESP with status OK.
  - A result_valid with a non-matching ID is consumed and dropped.
  - When the timeout counter reaches TIMEOUT-1 with no match, go to RESP with status TIMEOUT; resp_data = 0 and resp_rd = 0.
- **result_ready during COMMIT:** also 1 when the instruction is accepted and not killed, because the coprocessor raises result_valid combinationally with commit_valid.
- **RESP:**
  - resp_valid = 1; resp_data, resp_rd and resp_status stay stable until resp_ready.
  - On handshake, go to IDLE and increment the ID counter modulo 2^X_ID_WIDTH.
- **ID counter behaviour:**
  - The counter increments once per completed request, whatever the status.
  - It wraps from 2^X_ID_WIDTH-1 to 0.
- **Width rules:**
  - The timeout counter is $clog2(TIMEOUT) bits wide.
  - It clears on entry to WAIT_RESULT and saturates; it never wraps.

## Timing
- **Reset (rst_i high at a clock edge):**
  - State = IDLE, ID counter = 0.
  - issue_valid, commit_valid, commit_kill, result_ready and resp_valid = 0.
  - req_ready = 1 from the first cycle after reset.
  - All data outputs = 0.
- **Reset mid-operation:** abandons the transaction with no commit or response. Reset takes priority over every other event.
- **Best-case latency:**
  - req handshake at cycle 0.
  - issue_valid at cycle 1, with issue_ready in the same cycle.
  - commit_valid at cycle 2, with the result taken in the same cycle.
  - resp_valid at cycle 3.
- **Minimum request spacing:** 4 cycles; the next req_ready comes in the cycle after the resp handshake.
- **Stall rule:** no output changes while a valid is held and the matching ready is low.
- **Single-cycle signals:** commit_valid is never asserted for more than one cycle per ID.
- **Out-of-state handshakes:** result_valid outside COMMIT/WAIT_RESULT is ignored, and result_ready is 0 there.

## Test plan
- aes32esmi (instr 0x2620_0033, i.e. rs1=0 rs2=2 rd=0) with issue_ready at cycle 1, accept=1, result_valid with the commit → resp_valid at cycle 3, status 0, and resp_data/resp_rd equal to the coprocessor result.
- Non-AES instruction 0x0000_0013 → accept = 0, a single commit_valid with commit_kill = 1, then resp_status = 1 and result_ready stays 0 throughout.
- req_kill = 1 on an accepted instruction → commit_kill = 1, resp_status = 2, and no result_ready in WAIT_RESULT.
- Bench withholds issue_ready for 5 cycles and resp_ready for 3 cycles → issue and resp outputs stay constant, and only one commit occurs.
- TIMEOUT = 8 with no result → resp_status = 3 exactly 8 cycles after entering WAIT_RESULT; a result with the wrong ID during the wait is dropped.
- 17 back-to-back requests with X_ID_WIDTH = 4 → issue_id runs 0..15 then 0; assert rst_i during WAIT_RESULT → all valids are 0 the next cycle and the ID restarts at 0.
